// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcodes, microstep encoding and control word for the SAP CPU
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic ram_out;
    logic ram_in;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic out_in;
    logic pc_inc;
    logic pc_load;
  } ctrl_t;

endpackage

// File: rtl/sap_alu.sv
// rtl/sap_alu.sv - combinational A+B / A-B with carry (no-borrow on subtract) and zero
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_op;

  // Subtract as A + ~B + 1 so the carry-out reads directly as "A >= B".
  always_comb begin
    b_op   = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
    result = sum[DATA_W-1:0];
    carry  = sum[DATA_W];
    zero   = (sum[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/sap_cpu_param.sv
// rtl/sap_cpu_param.sv - parametrised single-bus SAP CPU with step-enable and program port
// Optional SAP_DEBUG_BUS_EN exposes bus_dbg and step_dbg.
module sap_cpu_param
  import sap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_en,
  input  logic                run,
  input  logic                prog_we,
  input  logic [DATA_W-5:0]   prog_addr,
  input  logic [DATA_W-1:0]   prog_data,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic                halted,
  output logic                flag_c,
  output logic                flag_z
`ifdef SAP_DEBUG_BUS_EN
  ,
  output logic [DATA_W-1:0]   bus_dbg,
  output logic [2:0]          step_dbg
`endif
);

  localparam int ADDR_W = DATA_W - 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d, flag_c_q, flag_c_d;
  logic              flag_z_q, flag_z_d, halted_q, halted_d;
  step_t             step_q, step_d;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_rd, bus, alu_res;
  logic [3:0]        ir_op;
  logic              adv, last, hlt, flags_we, alu_c, alu_z;
  ctrl_t             ctrl;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign adv    = step_en & run & ~halted_q;
  assign ram_rd = ram_q[mar_q];
  assign ir_op  = ir_q[DATA_W-1:ADDR_W];

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sub    (ctrl.alu_sub),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Microcode: control word for the current step and instruction.
  always_comb begin
    ctrl     = '0;
    last     = 1'b0;
    hlt      = 1'b0;
    flags_we = 1'b0;
    case (step_q)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      T1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
        // IR is not loaded yet, so NOP is recognised from the word on the bus.
        last = (ram_rd[DATA_W-1:ADDR_W] == OP_NOP);
      end
      T2: begin
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
            last        = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_load = (ir_op == OP_JMP) || (ir_op == OP_JC && flag_c_q) ||
                           (ir_op == OP_JZ && flag_z_q);
            last         = 1'b1;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
            last        = 1'b1;
          end
          OP_HLT: begin
            hlt  = 1'b1;
            last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T3: begin
        case (ir_op)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
            last         = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
            last        = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      T4: begin
        ctrl.alu_out = 1'b1;
        ctrl.alu_sub = (ir_op == OP_SUB);
        ctrl.a_in    = 1'b1;
        flags_we     = 1'b1;
        last         = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

  always_comb begin
    bus = '0;
    if (ctrl.pc_out)  bus = DATA_W'(pc_q);
    if (ctrl.ram_out) bus = ram_rd;
    if (ctrl.ir_out)  bus = DATA_W'(ir_q[ADDR_W-1:0]);
    if (ctrl.a_out)   bus = a_q;
    if (ctrl.alu_out) bus = alu_res;
  end

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    halted_d    = halted_q;
    step_d      = step_q;
    if (adv) begin
      if (ctrl.mar_in)  mar_d = bus[ADDR_W-1:0];
      if (ctrl.ir_in)   ir_d = bus;
      if (ctrl.pc_inc)  pc_d = pc_q + ADDR_W'(1);
      if (ctrl.pc_load) pc_d = bus[ADDR_W-1:0];
      if (ctrl.a_in)    a_d = bus;
      if (ctrl.b_in)    b_d = bus;
      if (ctrl.out_in)  out_data_d = bus;
      out_valid_d = ctrl.out_in;
      if (flags_we) begin
        flag_c_d = alu_c;
        flag_z_d = alu_z;
      end
      if (hlt) halted_d = 1'b1;
      step_d = last ? T0 : step_t'(step_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      halted_q    <= 1'b0;
      step_q      <= T0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      halted_q    <= halted_d;
      step_q      <= step_d;
    end
  end

  // STA only writes while run=1 and the program port only while run=0.
  assign ram_we    = (adv & ctrl.ram_in) | (~run & prog_we);
  assign ram_waddr = run ? mar_q : prog_addr;
  assign ram_wdata = run ? bus : prog_data;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;

`ifdef SAP_DEBUG_BUS_EN
  assign bus_dbg  = bus;
  assign step_dbg = step_q;
`endif

endmodule

// File: tb/tb_sap_cpu_param.sv
// tb/tb_sap_cpu_param.sv - directed self-checking bench for sap_cpu_param (DATA_W=8)
module tb_sap_cpu_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_en;
  logic       run;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       flag_c;
  logic       flag_z;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [16];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         obs_rd = 0;

  sap_cpu_param #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_en   (step_en),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .flag_c    (flag_c),
    .flag_z    (flag_z)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    chk({tag, "_nout"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        chk(tag, 32'(obs_q[obs_rd]), 32'(e));
        obs_rd++;
      end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset();
    run     = 1'b0;
    step_en = 1'b0;
    prog_we = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_and_start();
    run     = 1'b0;
    step_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prog_addr = 4'(i);
      prog_data = img[i];
      prog_we   = 1'b1;
      @(negedge clk);
    end
    prog_we = 1'b0;
    run     = 1'b1;
    step_en = 1'b1;
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_to_halt(input string tag);
    int k;
    k = 0;
    while (!halted && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_halt"}, 32'(halted), 32'd1);
  endtask

  initial begin
    prog_addr = '0;
    prog_data = '0;
    do_reset();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_flags", {30'h0, flag_c, flag_z}, 32'h0);
    chk("rst_pc", 32'(dut.pc_q), 32'h0);

    // LDA 15, ADD 15, OUT, HLT with RAM[15]=3
    clear_img();
    img[0] = 8'h1F; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
    load_and_start();
    exp_q.push_back(8'h06);
    steps(14);
    chk("p1_not_halted_14", 32'(halted), 32'h0);
    steps(1);
    chk("p1_halted_15", 32'(halted), 32'h1);
    steps(10);
    chk("p1_out_hold", 32'(out_data), 32'h06);
    chk("p1_pc_hold", 32'(dut.pc_q), 32'h4);
    drain("p1_out");

    // program port ignored while run=1, honoured while halted with run=0
    prog_addr = 4'd15; prog_data = 8'hAA; prog_we = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    chk("prog_we_run1", 32'(dut.ram_q[15]), 32'h03);
    run = 1'b0;
    prog_addr = 4'd14; prog_data = 8'h5A; prog_we = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    chk("prog_we_halted", 32'(dut.ram_q[14]), 32'h5A);

    // LDI 5, SUB 14, JZ 6, ..., OUT at 6
    do_reset();
    clear_img();
    img[0] = 8'h55; img[1] = 8'h3E; img[2] = 8'h86; img[3] = 8'hF0; img[4] = 8'hF0;
    img[5] = 8'hF0; img[6] = 8'hE0; img[7] = 8'hF0; img[14] = 8'h05;
    load_and_start();
    exp_q.push_back(8'h00);
    steps(11);
    chk("sub_a", 32'(dut.a_q), 32'h0);
    chk("sub_flags_cz", {30'h0, flag_c, flag_z}, 32'h3);
    chk("jz_pc", 32'(dut.pc_q), 32'h6);
    run_to_halt("sub");
    drain("sub_out");

    // LDI 15, ADD 14, JC 5 with carry and without
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      clear_img();
      img[0] = 8'h5F; img[1] = 8'h2E; img[2] = 8'h75; img[3] = 8'hE0; img[4] = 8'hF0;
      img[5] = 8'h51; img[6] = 8'hE0; img[7] = 8'hF0;
      img[14] = (pass == 0) ? 8'hF8 : 8'h01;
      load_and_start();
      exp_q.push_back((pass == 0) ? 8'h01 : 8'h10);
      steps(8);
      chk("add_a", 32'(dut.a_q), (pass == 0) ? 32'h07 : 32'h10);
      chk("add_flags_cz", {30'h0, flag_c, flag_z}, (pass == 0) ? 32'h2 : 32'h0);
      steps(3);
      chk("jc_pc", 32'(dut.pc_q), (pass == 0) ? 32'h5 : 32'h3);
      run_to_halt("jc");
      drain("jc_out");
    end

    // STA readback
    do_reset();
    clear_img();
    img[0] = 8'h59; img[1] = 8'h4D; img[2] = 8'h50; img[3] = 8'h1D; img[4] = 8'hE0; img[5] = 8'hF0;
    load_and_start();
    exp_q.push_back(8'h09);
    run_to_halt("sta");
    chk("sta_ram13", 32'(dut.ram_q[13]), 32'h09);
    drain("sta_out");

    // step_en high one cycle in four: same program, four times the cycles
    do_reset();
    clear_img();
    img[0] = 8'h1F; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
    load_and_start();
    exp_q.push_back(8'h06);
    for (int i = 0; i < 56; i++) begin
      step_en = (i % 4 == 0);
      @(negedge clk);
    end
    chk("gate_not_halted_56", 32'(halted), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step_en = (i == 0);
      @(negedge clk);
    end
    chk("gate_halted_60", 32'(halted), 32'h1);
    drain("gate_out");

    // NOP sweep: PC wraps 15 -> 0
    do_reset();
    clear_img();
    load_and_start();
    steps(30);
    chk("wrap_pc15", 32'(dut.pc_q), 32'hF);
    steps(2);
    chk("wrap_pc0", 32'(dut.pc_q), 32'h0);
    chk("nop_flags", {30'h0, flag_c, flag_z}, 32'h0);

    // asynchronous reset during ADD T3
    do_reset();
    clear_img();
    img[0] = 8'h1F; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h03;
    load_and_start();
    steps(7);
    chk("pre_rst_step", 32'(dut.step_q), 32'h3);
    chk("pre_rst_a", 32'(dut.a_q), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(dut.pc_q), 32'h0);
    chk("arst_a", 32'(dut.a_q), 32'h0);
    chk("arst_mar_ir", {16'h0, 4'h0, dut.mar_q, dut.ir_q}, 32'h0);
    chk("arst_step", 32'(dut.step_q), 32'h0);
    chk("arst_outs", {27'h0, out_valid, halted, flag_c, flag_z, |out_data}, 32'h0);
    chk("arst_ram15", 32'(dut.ram_q[15]), 32'h03);
    chk("arst_ram0", 32'(dut.ram_q[0]), 32'h1F);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h06);
    steps(14);
    chk("restart_not_halted", 32'(halted), 32'h0);
    steps(1);
    chk("restart_halted", 32'(halted), 32'h1);
    drain("restart_out");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
